// File: rtl/param_mode_queue.sv
// Single-clock valid/ready FIFO with normal, pipe and bypass flow modes.
// Reports occupancy and an almost-full flag derived purely from the stored count.
module param_mode_queue #(
    parameter int p_data_width   = 16,
    parameter int p_num_entries  = 2,
    parameter int p_mode         = 0,
    parameter int p_afull_thresh = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   w_val,
    output logic                                   w_rdy,
    input  logic [p_data_width-1:0]                w_msg,
    output logic                                   r_val,
    input  logic                                   r_rdy,
    output logic [p_data_width-1:0]                r_msg,
    output logic [$clog2(p_num_entries+1)-1:0]     count,
    output logic                                   almost_full
);

    localparam int CW = $clog2(p_num_entries + 1);
    localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

    localparam logic [CW-1:0] full_count  = CW'(p_num_entries);
    localparam logic [CW-1:0] afull_count = CW'(p_afull_thresh);
    localparam logic [PW-1:0] last_ptr    = PW'(p_num_entries - 1);

    logic [p_data_width-1:0] mem [p_num_entries];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_next;

    logic pipe_en;
    logic bypass_en;
    logic full;
    logic empty;
    logic enq;
    logic deq;
    logic pass_through;
    logic enq_stored;
    logic deq_stored;

    // Pointers wrap explicitly at N-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == last_ptr) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Decode the flow-through mode; unknown encodings fall back to normal.
    always_comb begin
        pipe_en   = 1'b0;
        bypass_en = 1'b0;
        case (p_mode)
            32'sd1:  pipe_en   = 1'b1;
            32'sd2:  bypass_en = 1'b1;
            default: begin
                pipe_en   = 1'b0;
                bypass_en = 1'b0;
            end
        endcase
    end

    assign full  = (count == full_count);
    assign empty = (count == {CW{1'b0}});

    // Handshake outputs and head message selection.
    always_comb begin
        w_rdy = ~full;
        r_val = ~empty & ~reset;
        r_msg = mem[rd_ptr];
        if (pipe_en) begin
            w_rdy = ~full | r_rdy;
        end else begin
            w_rdy = ~full;
        end
        if (bypass_en) begin
            r_val = (~empty | w_val) & ~reset;
            if (empty) begin
                r_msg = w_msg;
            end else begin
                r_msg = mem[rd_ptr];
            end
        end else begin
            r_val = ~empty & ~reset;
            r_msg = mem[rd_ptr];
        end
    end

    // Firing is gated internally, so illegal handshakes and reset cycles do nothing.
    assign enq          = w_val & w_rdy & ~reset;
    assign deq          = r_val & r_rdy & ~reset;
    assign pass_through = bypass_en & empty & enq & deq;
    assign enq_stored   = enq & ~pass_through;
    assign deq_stored   = deq & ~pass_through;

    // Next occupancy from the stored enqueue/dequeue pair.
    always_comb begin
        count_next = count;
        case ({enq_stored, deq_stored})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Control state: pointers, occupancy and the almost-full flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (enq_stored) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq_stored) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count       <= count_next;
            almost_full <= (count_next >= afull_count);
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (enq_stored) begin
            mem[wr_ptr] <= w_msg;
        end
    end

endmodule

// File: tb/tb_param_mode_queue.sv
// Directed and randomized checks of param_mode_queue across modes and depths.
module tb_param_mode_queue;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    // normal, N=2, almost-full at 2
    logic        a_w_val, a_w_rdy, a_r_val, a_r_rdy, a_af;
    logic [15:0] a_w_msg, a_r_msg;
    logic [1:0]  a_count;
    // normal, N=3
    logic        b_w_val, b_w_rdy, b_r_val, b_r_rdy, b_af;
    logic [15:0] b_w_msg, b_r_msg;
    logic [1:0]  b_count;
    // pipe, N=2
    logic        c_w_val, c_w_rdy, c_r_val, c_r_rdy, c_af;
    logic [15:0] c_w_msg, c_r_msg;
    logic [1:0]  c_count;
    // bypass, N=2
    logic        d_w_val, d_w_rdy, d_r_val, d_r_rdy, d_af;
    logic [15:0] d_w_msg, d_r_msg;
    logic [1:0]  d_count;

    // random: modes 0..2 x N in {1,2,5}
    logic        rw_val [9];
    logic        rw_rdy [9];
    logic [15:0] rw_msg [9];
    logic        rr_val [9];
    logic        rr_rdy [9];
    logic [15:0] rr_msg [9];
    logic        r_af   [9];
    logic [2:0]  rcnt   [9];

    param_mode_queue #(.p_data_width(16), .p_num_entries(2), .p_mode(0), .p_afull_thresh(2)) u_a (
        .clk(clk), .reset(reset), .w_val(a_w_val), .w_rdy(a_w_rdy), .w_msg(a_w_msg),
        .r_val(a_r_val), .r_rdy(a_r_rdy), .r_msg(a_r_msg), .count(a_count), .almost_full(a_af));
    param_mode_queue #(.p_data_width(16), .p_num_entries(3), .p_mode(0), .p_afull_thresh(3)) u_b (
        .clk(clk), .reset(reset), .w_val(b_w_val), .w_rdy(b_w_rdy), .w_msg(b_w_msg),
        .r_val(b_r_val), .r_rdy(b_r_rdy), .r_msg(b_r_msg), .count(b_count), .almost_full(b_af));
    param_mode_queue #(.p_data_width(16), .p_num_entries(2), .p_mode(1), .p_afull_thresh(1)) u_c (
        .clk(clk), .reset(reset), .w_val(c_w_val), .w_rdy(c_w_rdy), .w_msg(c_w_msg),
        .r_val(c_r_val), .r_rdy(c_r_rdy), .r_msg(c_r_msg), .count(c_count), .almost_full(c_af));
    param_mode_queue #(.p_data_width(16), .p_num_entries(2), .p_mode(2), .p_afull_thresh(1)) u_d (
        .clk(clk), .reset(reset), .w_val(d_w_val), .w_rdy(d_w_rdy), .w_msg(d_w_msg),
        .r_val(d_r_val), .r_rdy(d_r_rdy), .r_msg(d_r_msg), .count(d_count), .almost_full(d_af));

    function automatic int rn(input int g);
        case (g % 3)
            0:       return 1;
            1:       return 2;
            default: return 5;
        endcase
    endfunction

    for (genvar g = 0; g < 9; g++) begin : g_rnd
        localparam int N = rn(g);
        localparam int M = g / 3;
        logic [$clog2(N+1)-1:0] cnt;
        param_mode_queue #(.p_data_width(16), .p_num_entries(N), .p_mode(M), .p_afull_thresh(N)) u_r (
            .clk(clk), .reset(reset), .w_val(rw_val[g]), .w_rdy(rw_rdy[g]), .w_msg(rw_msg[g]),
            .r_val(rr_val[g]), .r_rdy(rr_rdy[g]), .r_msg(rr_msg[g]), .count(cnt), .almost_full(r_af[g]));
        assign rcnt[g] = 3'(cnt);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int  sent [9];
    int  rcvd [9];
    int  mcnt, bs, br;
    bit  fe, fd, done;

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b0;
        a_w_val = 1'b0; a_r_rdy = 1'b0; a_w_msg = 16'h0000;
        b_w_val = 1'b0; b_r_rdy = 1'b0; b_w_msg = 16'h0000;
        c_w_val = 1'b0; c_r_rdy = 1'b0; c_w_msg = 16'h0000;
        d_w_val = 1'b0; d_r_rdy = 1'b0; d_w_msg = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            rw_val[i] = 1'b0; rr_rdy[i] = 1'b0; rw_msg[i] = 16'h0000;
            sent[i] = 0; rcvd[i] = 0;
        end
        #1 reset = 1'b1;
        #1;
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_r_val", 32'(a_r_val), 32'd0);
        chk("rst_w_rdy", 32'(a_w_rdy), 32'd1);
        chk("rst_afull", 32'(a_af), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // 1: normal N=2 fill then drain
        a_w_val = 1'b1; a_w_msg = 16'h0005;
        tick();
        a_w_msg = 16'h000A; #1;
        chk("t1_count1", 32'(a_count), 32'd1);
        chk("t1_afull1", 32'(a_af), 32'd0);
        chk("t1_head1", 32'(a_r_msg), 32'h0005);
        tick();
        a_w_val = 1'b0; #1;
        chk("t1_count2", 32'(a_count), 32'd2);
        chk("t1_w_rdy", 32'(a_w_rdy), 32'd0);
        chk("t1_afull2", 32'(a_af), 32'd1);
        chk("t1_out0", 32'(a_r_msg), 32'h0005);
        a_r_rdy = 1'b1;
        tick(); #1;
        chk("t1_out1", 32'(a_r_msg), 32'h000A);
        chk("t1_count3", 32'(a_count), 32'd1);
        tick(); #1;
        chk("t1_empty", 32'(a_r_val), 32'd0);
        chk("t1_count4", 32'(a_count), 32'd0);
        a_r_rdy = 1'b0;

        // 2: normal N=3 streaming with toggling r_rdy
        mcnt = 0; bs = 0; br = 0;
        for (int cyc = 0; cyc < 60 && br < 10; cyc++) begin
            b_w_val = (bs < 10);
            b_w_msg = 16'(16'h0100 + bs);
            b_r_rdy = cyc[0];
            #1;
            chk("t2_count", 32'(b_count), 32'(mcnt));
            chk("t2_w_rdy", 32'(b_w_rdy), 32'(mcnt != 3));
            chk("t2_r_val", 32'(b_r_val), 32'(mcnt != 0));
            fe = b_w_val && (mcnt != 3);
            fd = b_r_rdy && (mcnt != 0);
            if (fd) begin
                chk("t2_msg", 32'(b_r_msg), 32'(16'h0100 + br));
                br++;
            end
            if (fe) bs++;
            mcnt = mcnt + int'(fe) - int'(fd);
            tick();
        end
        b_w_val = 1'b0; b_r_rdy = 1'b0;
        chk("t2_delivered", 32'(br), 32'd10);

        // 3: pipe N=2, full with simultaneous enq/deq
        c_w_val = 1'b1; c_w_msg = 16'h0063;
        tick();
        c_w_msg = 16'h002A;
        tick();
        c_w_val = 1'b0; #1;
        chk("t3_full", 32'(c_count), 32'd2);
        chk("t3_w_rdy0", 32'(c_w_rdy), 32'd0);
        c_w_val = 1'b1; c_w_msg = 16'h0052; c_r_rdy = 1'b1; #1;
        chk("t3_w_rdy1", 32'(c_w_rdy), 32'd1);
        chk("t3_out", 32'(c_r_msg), 32'h0063);
        tick();
        c_w_val = 1'b0; c_r_rdy = 1'b0; #1;
        chk("t3_count", 32'(c_count), 32'd2);
        chk("t3_head", 32'(c_r_msg), 32'h002A);
        c_r_rdy = 1'b1;
        tick(); #1;
        chk("t3_next", 32'(c_r_msg), 32'h0052);
        chk("t3_count1", 32'(c_count), 32'd1);
        tick();
        c_r_rdy = 1'b0; #1;
        chk("t3_count0", 32'(c_count), 32'd0);

        // 4: bypass N=2
        d_w_val = 1'b1; d_w_msg = 16'h0017; d_r_rdy = 1'b1; #1;
        chk("t4_r_val", 32'(d_r_val), 32'd1);
        chk("t4_pass", 32'(d_r_msg), 32'h0017);
        tick();
        d_w_val = 1'b0; d_r_rdy = 1'b0; #1;
        chk("t4_count", 32'(d_count), 32'd0);
        chk("t4_r_val0", 32'(d_r_val), 32'd0);
        d_w_val = 1'b1; d_w_msg = 16'h0011; #1;
        chk("t4_peek", 32'(d_r_msg), 32'h0011);
        tick();
        d_w_msg = 16'h0022; #1;
        chk("t4_head", 32'(d_r_msg), 32'h0011);
        chk("t4_count1", 32'(d_count), 32'd1);
        tick();
        d_w_val = 1'b0; d_r_rdy = 1'b1;
        tick(); #1;
        chk("t4_second", 32'(d_r_msg), 32'h0022);
        tick(); #1;
        chk("t4_drained", 32'(d_count), 32'd0);
        d_r_rdy = 1'b0;

        // 5: asynchronous reset mid-operation
        a_w_val = 1'b1; a_w_msg = 16'h0001;
        tick();
        a_w_msg = 16'h0002;
        tick(); #1;
        chk("t5_full", 32'(a_count), 32'd2);
        reset = 1'b1; #1;
        chk("t5_count", 32'(a_count), 32'd0);
        chk("t5_r_val", 32'(a_r_val), 32'd0);
        chk("t5_w_rdy", 32'(a_w_rdy), 32'd1);
        chk("t5_afull", 32'(a_af), 32'd0);
        tick(); #1;
        chk("t5_no_enq", 32'(a_count), 32'd0);
        reset = 1'b0; a_w_val = 1'b0;
        tick(); #1;
        chk("t5_after", 32'(a_count), 32'd0);
        chk("t5_after_rv", 32'(a_r_val), 32'd0);

        // 6: random traffic across all modes and depths
        done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            for (int i = 0; i < 9; i++) begin
                rw_val[i] = (sent[i] < 100) && ($urandom_range(0, 1) == 1);
                rw_msg[i] = 16'(i * 1000 + sent[i]);
                rr_rdy[i] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int i = 0; i < 9; i++) begin
                if (rr_val[i] && rr_rdy[i]) begin
                    chk("t6_msg", 32'(rr_msg[i]), 32'(16'(i * 1000 + rcvd[i])));
                    rcvd[i]++;
                end
                if (rw_val[i] && rw_rdy[i]) sent[i]++;
            end
            tick();
            done = 1'b1;
            for (int i = 0; i < 9; i++) begin
                if (rcvd[i] < 100) done = 1'b0;
            end
        end
        for (int i = 0; i < 9; i++) begin
            rw_val[i] = 1'b0; rr_rdy[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 9; i++) begin
            chk("t6_total", 32'(rcvd[i]), 32'd100);
            chk("t6_count", 32'(rcvd[i] == 100 ? rcnt[i] : 3'd7), 32'd0);
            chk("t6_afull", 32'(r_af[i]), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
